eh2_exu_mul_wb_ctl: RTL and testbench

EH2_EXU_MUL_WB_CTL -- requirements
Module: eh2_exu_mul_wb_ctl

---
 rtl/eh2_pkg.sv | 31 +++
 rtl/eh2_exu_mul_wb_fifo.sv | 76 +++++++
 rtl/eh2_exu_mul_wb_ctl.sv | 131 +++++++++++++
 tb/tb_eh2_exu_mul_wb_ctl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/eh2_pkg.sv
// Shared types and constants for the EH2 execute-unit multiply writeback path.
package eh2_pkg;

    // Issue-to-e3 distance of the multiplier pipeline (e1, e2, e3).
    localparam int MUL_WB_LAT    = 3;

    // Widest destination index a tag can carry; RF_ADDR_W must not exceed it.
    localparam int RF_ADDR_MAX_W = 8;

    // Per-stage tag that rides alongside a multiply through e1..e3.
    typedef struct packed {
        logic                     valid;
        logic                     tid;
        logic [RF_ADDR_MAX_W-1:0] rd;
    } eh2_mul_wb_tag_t;

    // True when the tag holds a live multiply of thread tid.
    function automatic logic tag_hit(input eh2_mul_wb_tag_t t, input logic tid);
        return t.valid & (t.tid == tid);
    endfunction

    // Advance a pre-e3 tag by one stage, killing it if its thread is flushed.
    function automatic eh2_mul_wb_tag_t tag_adv(input eh2_mul_wb_tag_t t,
                                                input logic [1:0]      flush);
        eh2_mul_wb_tag_t r;
        r = t;
        if (flush[t.tid]) r.valid = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/eh2_exu_mul_wb_fifo.sv
// Skid FIFO for committed multiply results awaiting the register-file arbiter.
// Pointers wrap modulo DEPTH so any depth works; a per-slot valid mask is kept
// so the owner can see which thread each resident entry belongs to.
module eh2_exu_mul_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 38
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty,
    output logic [DEPTH-1:0]           o_slot_vld,
    output logic [DEPTH-1:0]           o_slot_msb
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [PTR_W-1:0]            r_wr_ptr;
    logic [PTR_W-1:0]            r_rd_ptr;
    logic [CNT_W-1:0]            r_count;
    logic [DEPTH-1:0]            r_vld;
    logic                        w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    // A pop on an empty FIFO is ignored rather than corrupting the pointers.
    assign w_pop      = i_pop & ~o_empty;
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_head     = r_mem[r_rd_ptr];
    assign o_slot_vld = r_vld;

    // Expose each slot's top bit (the thread id in the owner's packing).
    always_comb begin
        o_slot_msb = '0;
        for (int i = 0; i < DEPTH; i++) o_slot_msb[i] = r_mem[i][WIDTH-1];
    end

    // Pointer, occupancy and slot-valid bookkeeping; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_vld    <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr        <= ptr_inc(r_rd_ptr);
                r_vld[r_rd_ptr] <= 1'b0;
            end
            if (i_push) begin
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
                r_vld[r_wr_ptr] <= 1'b1;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; stale slots are masked by r_vld.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/eh2_exu_mul_wb_ctl.sv
// Multiply writeback control: tracks {valid, tid, rd} tags through e1..e3,
// joins them with the e3 multiplier result, and queues the result in a skid
// FIFO toward the register-file arbiter. Issue is credit-limited so the FIFO
// can never overflow even if every in-flight multiply ends up stalled.
// Optional: define EXU_MUL_WB_BYPASS_EN to present e3 directly on wb_* when
// the FIFO is empty (writeback at issue+3 instead of issue+4).
module eh2_exu_mul_wb_ctl
    import eh2_pkg::*;
#(
    parameter int RF_ADDR_W  = 5,
    parameter int SKID_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  logic                 issue_tid,
    input  logic [RF_ADDR_W-1:0] issue_rd,
    output logic                 issue_ready,
    input  logic [1:0]           flush,
    input  logic [31:0]          mul_result_e3,
    output logic                 wb_valid,
    output logic                 wb_tid,
    output logic [RF_ADDR_W-1:0] wb_rd,
    output logic [31:0]          wb_data,
    input  logic                 wb_ready,
    output logic [1:0]           busy
);

    localparam int ENT_W = 1 + RF_ADDR_W + 32;
    localparam int CNT_W = $clog2(SKID_DEPTH+1);
    localparam int USE_W = CNT_W + 2;

    eh2_mul_wb_tag_t        r_tag [MUL_WB_LAT];
    eh2_mul_wb_tag_t        w_iss_tag;
    eh2_mul_wb_tag_t        w_e3;
    logic                   w_iss_acc;
    logic                   w_rdy;
    logic [USE_W-1:0]       w_used;
    logic [CNT_W-1:0]       w_fifo_cnt;
    logic                   w_fifo_empty;
    logic [SKID_DEPTH-1:0]  w_slot_vld;
    logic [SKID_DEPTH-1:0]  w_slot_msb;
    logic [ENT_W-1:0]       w_head;
    logic [ENT_W-1:0]       w_e3_ent;
    logic [ENT_W-1:0]       w_wb_ent;
    logic                   w_byp;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_wb_vld;
    logic [1:0]             w_busy;
    logic                   w_unused_rd;

    assign w_e3 = r_tag[MUL_WB_LAT-1];

    // Credits: every live tag and every queued entry holds one FIFO slot.
    always_comb begin
        w_used = USE_W'(w_fifo_cnt);
        for (int i = 0; i < MUL_WB_LAT; i++) w_used = w_used + USE_W'(r_tag[i].valid);
    end

    assign w_rdy       = (w_used < USE_W'(SKID_DEPTH));
    assign issue_ready = rst | w_rdy;

    // A same-cycle flush of the issuing thread drops the issue outright.
    assign w_iss_acc       = issue_valid & w_rdy & ~rst & ~flush[issue_tid];
    assign w_iss_tag.valid = w_iss_acc;
    assign w_iss_tag.tid   = issue_tid;
    assign w_iss_tag.rd    = RF_ADDR_MAX_W'(issue_rd);

    // Unstalled tag pipeline; flush kills tags leaving e1 and e2, never e3.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MUL_WB_LAT; i++) r_tag[i] <= '0;
        end else begin
            r_tag[0] <= w_iss_tag;
            for (int i = 1; i < MUL_WB_LAT; i++) r_tag[i] <= tag_adv(r_tag[i-1], flush);
        end
    end

    // Upper rd bits beyond RF_ADDR_W are padding in the tag.
    assign w_unused_rd = ^w_e3.rd;
    assign w_e3_ent    = {w_e3.tid, w_e3.rd[RF_ADDR_W-1:0], mul_result_e3};

`ifdef EXU_MUL_WB_BYPASS_EN
    // Only bypass when nothing older is queued, so order is preserved.
    assign w_byp = w_fifo_empty & w_e3.valid;
`else
    assign w_byp = 1'b0;
`endif

    // A bypassed result that is not accepted this cycle falls into the FIFO
    // and becomes the head next cycle, so wb_* stays stable under backpressure.
    assign w_push   = w_e3.valid & ~(w_byp & wb_ready);
    assign w_pop    = ~w_fifo_empty & wb_ready;
    assign w_wb_vld = ~rst & (~w_fifo_empty | w_byp);
    assign w_wb_ent = w_byp ? w_e3_ent : w_head;

    assign wb_valid = w_wb_vld;
    assign wb_tid   = w_wb_vld & w_wb_ent[ENT_W-1];
    assign wb_rd    = w_wb_vld ? w_wb_ent[32 +: RF_ADDR_W] : '0;
    assign wb_data  = w_wb_vld ? w_wb_ent[31:0] : '0;

    eh2_exu_mul_wb_fifo #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_wdata    (w_e3_ent),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_count    (w_fifo_cnt),
        .o_empty    (w_fifo_empty),
        .o_slot_vld (w_slot_vld),
        .o_slot_msb (w_slot_msb)
    );

    // Per-thread busy from live tags and resident FIFO entries.
    always_comb begin
        w_busy = '0;
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < MUL_WB_LAT; i++) w_busy[t] = w_busy[t] | tag_hit(r_tag[i], t[0]);
            for (int s = 0; s < SKID_DEPTH; s++)
                w_busy[t] = w_busy[t] | (w_slot_vld[s] & (w_slot_msb[s] == t[0]));
        end
    end

    assign busy = rst ? 2'b00 : w_busy;

endmodule

// File: tb/tb_eh2_exu_mul_wb_ctl.sv
// Directed bench for eh2_exu_mul_wb_ctl. The e3 result is driven as
// D000_0000 | cycle, so a multiply issued in cycle N carries data D000_0000|(N+3).
module tb_eh2_exu_mul_wb_ctl;

    localparam int RW = 5;
`ifdef EXU_MUL_WB_BYPASS_EN
    localparam int WB_LAT = 3;
`else
    localparam int WB_LAT = 4;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid;
    logic          issue_tid;
    logic [RW-1:0] issue_rd;
    logic          issue_ready;
    logic [1:0]    flush;
    logic [31:0]   mul_result_e3;
    logic          wb_valid;
    logic          wb_tid;
    logic [RW-1:0] wb_rd;
    logic [31:0]   wb_data;
    logic          wb_ready;
    logic [1:0]    busy;

    eh2_exu_mul_wb_ctl #(.RF_ADDR_W(RW), .SKID_DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_tid     (issue_tid),
        .issue_rd      (issue_rd),
        .issue_ready   (issue_ready),
        .flush         (flush),
        .mul_result_e3 (mul_result_e3),
        .wb_valid      (wb_valid),
        .wb_tid        (wb_tid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .wb_ready      (wb_ready),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic          tid;
        logic [RW-1:0] rd;
        logic [31:0]   data;
    } wb_ev_t;

    wb_ev_t        ev_q[$];
    int            cyc;
    int            n_cmp;
    int            n_err;
    int            t0;
    int            t1;
    logic          s_rdy;
    logic          s_wbv;
    logic [1:0]    s_busy;
    logic [RW-1:0] s_wbrd;
    logic [31:0]   s_wbdata;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] dat(input int c);
        return 32'hD000_0000 | 32'(c);
    endfunction

    // One cycle: snapshot outputs mid-cycle, log accepted writebacks, advance.
    task automatic step();
        wb_ev_t e;
        @(negedge clk);
        s_rdy    = issue_ready;
        s_wbv    = wb_valid;
        s_busy   = busy;
        s_wbrd   = wb_rd;
        s_wbdata = wb_data;
        if (wb_valid && wb_ready) begin
            e.cyc = cyc; e.tid = wb_tid; e.rd = wb_rd; e.data = wb_data;
            ev_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
        mul_result_e3 = dat(cyc);
    endtask

    task automatic chk_ev(input string tag, input int k, input int ecyc, input logic etid,
                          input int erd, input logic [31:0] edata);
        if (k < ev_q.size()) begin
            chk({tag, "_cyc"},  ev_q[k].cyc,  ecyc);
            chk({tag, "_tid"},  ev_q[k].tid,  etid);
            chk({tag, "_rd"},   ev_q[k].rd,   erd);
            chk({tag, "_data"}, ev_q[k].data, edata);
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0;
        rst = 1'b1; issue_valid = 1'b0; issue_tid = 1'b0; issue_rd = '0;
        flush = 2'b00; wb_ready = 1'b1; mul_result_e3 = dat(0);

        // Outputs are defined while reset is held, even before the first edge.
        #1;
        chk("rst_wbv",  wb_valid,    0);
        chk("rst_rdy",  issue_ready, 1);
        chk("rst_busy", busy,        0);
        chk("rst_data", wb_data,     0);
        @(posedge clk);
        #1;
        step();
        step();
        rst = 1'b0;

        // Back-to-back rd=5,6,7 on thread 0.
        t0 = cyc; ev_q.delete();
        for (int k = 0; k < 8; k++) begin
            issue_valid = (k < 3); issue_tid = 1'b0; issue_rd = RW'(5 + k);
            step();
            if (k < 3) chk("b2b_rdy", s_rdy, 1);
        end
        issue_valid = 1'b0;
        chk("b2b_n", ev_q.size(), 3);
        for (int k = 0; k < 3; k++) chk_ev("b2b", k, t0 + WB_LAT + k, 1'b0, 5 + k, dat(t0 + 3 + k));
        chk("b2b_busy", s_busy, 0);

        // Backpressure: issue every cycle with the arbiter stalled.
        t0 = cyc; ev_q.delete(); wb_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            issue_valid = 1'b1; issue_tid = k[0]; issue_rd = RW'(10 + k);
            step();
            chk("bp_rdy", s_rdy, (k < 4));
            if (k >= 8) begin
                chk("bp_hold_vld",  s_wbv,    1);
                chk("bp_hold_rd",   s_wbrd,   10);
                chk("bp_hold_data", s_wbdata, dat(t0 + 3));
            end
        end
        chk("bp_busy", s_busy, 2'b11);
        issue_valid = 1'b0; wb_ready = 1'b1; t1 = cyc;
        for (int k = 0; k < 8; k++) step();
        chk("bp_n", ev_q.size(), 4);
        for (int k = 0; k < 4; k++) chk_ev("bp", k, t1 + k, k[0], 10 + k, dat(t0 + 3 + k));
        chk("bp_busy_end", s_busy, 0);

        // Flush of thread 1 while its multiply already sits in e3.
        t0 = cyc; ev_q.delete();
        for (int k = 0; k < 10; k++) begin
            issue_valid = (k < 2); issue_tid = (k == 0); issue_rd = (k == 0) ? RW'(3) : RW'(4);
            flush = (k == 3) ? 2'b10 : 2'b00;
            step();
            if (k == WB_LAT)     chk("fl_busy1_wb",    s_busy[1], 1);
            if (k == WB_LAT + 1) chk("fl_busy1_after", s_busy[1], 0);
        end
        issue_valid = 1'b0; flush = 2'b00;
        chk("fl_n", ev_q.size(), 2);
        chk_ev("fl_rd3", 0, t0 + WB_LAT,     1'b1, 3, dat(t0 + 3));
        chk_ev("fl_rd4", 1, t0 + 1 + WB_LAT, 1'b0, 4, dat(t0 + 4));

        // Flush of thread 0 kills the e1 tag and the same-cycle issue.
        t0 = cyc; ev_q.delete();
        for (int k = 0; k < 8; k++) begin
            issue_valid = (k < 2); issue_tid = 1'b0; issue_rd = RW'(8 + k);
            flush = (k == 1) ? 2'b01 : 2'b00;
            step();
            if (k == 1) chk("fk_busy0_pre", s_busy[0], 1);
            if (k == 2) chk("fk_busy0",     s_busy[0], 0);
        end
        issue_valid = 1'b0; flush = 2'b00;
        chk("fk_n", ev_q.size(), 0);

        // Flush of thread 1 kills its e2 tag but spares thread 0 in e1.
        t0 = cyc; ev_q.delete();
        for (int k = 0; k < 9; k++) begin
            issue_valid = (k < 2); issue_tid = (k == 0); issue_rd = RW'(12 + k);
            flush = (k == 2) ? 2'b10 : 2'b00;
            step();
        end
        issue_valid = 1'b0; flush = 2'b00;
        chk("fe2_n", ev_q.size(), 1);
        chk_ev("fe2", 0, t0 + 1 + WB_LAT, 1'b0, 13, dat(t0 + 4));

        // Reset with three results queued and an issue in the reset cycle.
        t0 = cyc; ev_q.delete(); wb_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            issue_valid = (k < 3); issue_tid = 1'b0; issue_rd = RW'(20 + k);
            step();
        end
        chk("rm_wbv_pre",  s_wbv,  1);
        chk("rm_busy_pre", s_busy, 2'b01);
        rst = 1'b1; issue_valid = 1'b1; issue_rd = RW'(25); wb_ready = 1'b1;
        step();
        chk("rm_wbv_in",  s_wbv,  0);
        chk("rm_busy_in", s_busy, 0);
        rst = 1'b0; issue_valid = 1'b0;
        step();
        chk("rm_wbv_post",  s_wbv,  0);
        chk("rm_busy_post", s_busy, 0);
        chk("rm_rdy_post",  s_rdy,  1);
        for (int k = 0; k < 8; k++) step();
        chk("rm_n", ev_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
